// File: rtl/alu_unit.sv
// Single-cycle registered ALU: AND/OR/ADD/SLT/ADDU/SLL/SUB/SLTU with carry, overflow and zero flags.
// Define ALU_UNIT_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       shamt,
  output logic             cout,
  output logic             ovf,
  output logic             ze,
  output logic [WIDTH-1:0] R
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_ADD  = 3'd2,
    OP_SLT  = 3'd3,
    OP_ADDU = 3'd4,
    OP_SLL  = 3'd5,
    OP_SUB  = 3'd6,
    OP_SLTU = 3'd7
  } op_e;

  op_e              op;
  logic             issub;
  logic [WIDTH-1:0] addb;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             slt;
  logic             sltu;
  logic [WIDTH-1:0] nextr;
  logic             nextc;

  assign op    = op_e'(ctrl);
  assign issub = (op == OP_SUB);
  // Subtraction reuses the adder as A + ~B + 1, so carry means "no borrow".
  assign addb  = issub ? ~B : B;
  assign wide  = {1'b0, A} + {1'b0, addb} + {{WIDTH{1'b0}}, issub};
  assign sum   = wide[WIDTH-1:0];
  assign carry = wide[WIDTH];
  assign slt   = ($signed(A) < $signed(B));
  assign sltu  = (A < B);

  always_comb begin
    nextr = '0;
    nextc = 1'b0;
    case (op)
      OP_AND:  nextr = A & B;
      OP_OR:   nextr = A | B;
      OP_ADD:  begin nextr = sum; nextc = carry; end
      OP_SLT:  nextr = {{(WIDTH-1){1'b0}}, slt};
      OP_ADDU: begin nextr = sum; nextc = carry; end
      OP_SLL:  nextr = A << shamt;
      OP_SUB:  begin nextr = sum; nextc = carry; end
      OP_SLTU: nextr = {{(WIDTH-1){1'b0}}, sltu};
      default: nextr = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      R    <= '0;
      cout <= 1'b0;
      ze   <= 1'b1;
    end else begin
      R    <= nextr;
      cout <= nextc;
      ze   <= (nextr == '0);
    end
  end

`ifdef ALU_UNIT_OVF_EN
  logic nextv;

  // Overflow only when the result sign disagrees with what the operand signs allow.
  always_comb begin
    nextv = 1'b0;
    if (op == OP_ADD)
      nextv = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    else if (op == OP_SUB)
      nextv = (A[WIDTH-1] != B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else     ovf <= nextv;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors plus a random sweep, scored through a queue.
module tb_alu_unit;

`ifdef ALU_UNIT_OVF_EN
  localparam bit OVFEN = 1'b1;
`else
  localparam bit OVFEN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [2:0]  ctrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic        cout;
  logic        ovf;
  logic        ze;
  logic [31:0] R;

  typedef struct {
    string       tag;
    logic [31:0] r;
    logic        co;
    logic        ov;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   nAsserts = 0;
  int   nFail    = 0;

  alu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .A(A), .B(B), .shamt(shamt),
    .cout(cout), .ovf(ovf), .ze(ze), .R(R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model built on 64-bit arithmetic rather than a shared adder.
  function automatic void model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] s, output logic [31:0] r, output logic co,
                                output logic ov);
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    longint          sa = longint'($signed(a));
    longint          sb2 = longint'($signed(b));
    longint          st;
    longint unsigned ut;
    r = 32'h0; co = 1'b0; ov = 1'b0;
    case (c)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2, 3'd4: begin
        ut = ua + ub; r = ut[31:0]; co = ut[32];
        st = sa + sb2;
        if (c == 3'd2) ov = OVFEN && (st > 64'sd2147483647 || st < -64'sd2147483648);
      end
      3'd3: r = (sa < sb2) ? 32'd1 : 32'd0;
      3'd5: r = a << s;
      3'd6: begin
        ut = ua - ub; r = ut[31:0]; co = (ua >= ub);
        st = sa - sb2;
        ov = OVFEN && (st > 64'sd2147483647 || st < -64'sd2147483648);
      end
      default: r = (ua < ub) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input string tag, input logic [2:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] s, input logic [31:0] er,
                               input logic eco, input logic eov);
    exp_t e;
    @(negedge clk);
    ctrl = c; A = a; B = b; shamt = s;
    e.tag = tag; e.r = er; e.co = eco; e.ov = eov; e.z = (er == 32'h0);
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    nAsserts++;
    assert (sb.size() > 0) else begin
      nFail++;
      $error("[TB] FAIL scoreboard_empty got %0d entries exp >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      nAsserts++;
      assert (R === e.r) else begin
        nFail++; $error("[TB] FAIL %s.R got %h exp %h", e.tag, R, e.r);
      end
      nAsserts++;
      assert (cout === e.co) else begin
        nFail++; $error("[TB] FAIL %s.cout got %b exp %b", e.tag, cout, e.co);
      end
      nAsserts++;
      assert (ovf === e.ov) else begin
        nFail++; $error("[TB] FAIL %s.ovf got %b exp %b", e.tag, ovf, e.ov);
      end
      nAsserts++;
      assert (ze === e.z) else begin
        nFail++; $error("[TB] FAIL %s.ze got %b exp %b", e.tag, ze, e.z);
      end
    end
  endtask

  task automatic checkReset(input string tag);
    nAsserts++;
    assert (R === 32'h0) else begin
      nFail++; $error("[TB] FAIL %s.R got %h exp %h", tag, R, 32'h0);
    end
    nAsserts++;
    assert (cout === 1'b0) else begin
      nFail++; $error("[TB] FAIL %s.cout got %b exp 0", tag, cout);
    end
    nAsserts++;
    assert (ovf === 1'b0) else begin
      nFail++; $error("[TB] FAIL %s.ovf got %b exp 0", tag, ovf);
    end
    nAsserts++;
    assert (ze === 1'b1) else begin
      nFail++; $error("[TB] FAIL %s.ze got %b exp 1", tag, ze);
    end
  endtask

  task automatic randomOp(input int idx);
    logic [2:0]  c;
    logic [31:0] a, b, er;
    logic [4:0]  s;
    logic        eco, eov;
    c = 3'($urandom_range(0, 7));
    a = $urandom;
    b = (idx % 5 == 0) ? a : $urandom;
    s = 5'($urandom_range(0, 31));
    model(c, a, b, s, er, eco, eov);
    applyStimulus($sformatf("rand%0d_op%0d", idx, c), c, a, b, s, er, eco, eov);
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; ctrl = 3'd0; A = 32'h0; B = 32'h0; shamt = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    // First op after reset release appears after the first rising edge.
    applyStimulus("and", 3'd0, 32'hAAAAAAAA, 32'hFFFFFFFF, 5'd0, 32'hAAAAAAAA, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("add_wrap", 3'd2, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h0, 1'b1, 1'b0);
    checkOutput();
    applyStimulus("add_posovf", 3'd2, 32'h40000000, 32'h40000000, 5'd0, 32'h80000000, 1'b0, OVFEN);
    checkOutput();
    applyStimulus("add_negovf", 3'd2, 32'h80000000, 32'h80000000, 5'd0, 32'h0, 1'b1, OVFEN);
    checkOutput();
    applyStimulus("slt_a", 3'd3, 32'h80956829, 32'h60982375, 5'd0, 32'd1, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("sltu_a", 3'd7, 32'h80956829, 32'h60982375, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("slt_b", 3'd3, 32'hFFFFFFFF, 32'h0, 5'd0, 32'd1, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("sltu_b", 3'd7, 32'hFFFFFFFF, 32'h0, 5'd0, 32'd0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("sll5", 3'd5, 32'hF0F0F0F0, 32'h0, 5'd5, 32'h1E1E1E00, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("sll0", 3'd5, 32'h12345678, 32'hFFFFFFFF, 5'd0, 32'h12345678, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("sub", 3'd6, 32'hF0F0F0F0, 32'h00FF00F0, 5'd7, 32'hEFF1F000, 1'b1, 1'b0);
    checkOutput();
    applyStimulus("sub_borrow", 3'd6, 32'h00000001, 32'h00000002, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("sub_ovf", 3'd6, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b1, OVFEN);
    checkOutput();
    applyStimulus("addu_noovf", 3'd4, 32'h40000000, 32'h40000000, 5'd3, 32'h80000000, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("or_shamt", 3'd1, 32'h0F000000, 32'h000000F0, 5'd31, 32'h0F0000F0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus("and_zero", 3'd0, 32'h55555555, 32'hAAAAAAAA, 5'd0, 32'h0, 1'b0, 1'b0);
    checkOutput();

    // Load a nonzero result, then hit reset between edges.
    applyStimulus("pre_async", 3'd1, 32'hDEAD0000, 32'h0000BEEF, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0);
    checkOutput();
    #2;
    rst = 1'b1;
    #1;
    checkReset("async_reset");
    @(negedge clk);
    ctrl = 3'd2; A = 32'h80000000; B = 32'h80000000;
    @(posedge clk);
    #1;
    checkReset("reset_held_edge");
    @(negedge clk);
    rst = 1'b0;

    // An op presented just before reset must be discarded.
    applyStimulus("inflight", 3'd1, 32'h11111111, 32'h22222222, 5'd0, 32'h33333333, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkReset("inflight_discard");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("post_reset", 3'd4, 32'h00000005, 32'h00000007, 5'd0, 32'h0000000C, 1'b0, 1'b0);
    checkOutput();

    for (int i = 0; i < 40; i++) randomOp(i);

    $display("[TB] directed and random sequences complete");
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; verified only at 32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 ctrl  input  3  operation select.
REQ-005 A  input  WIDTH  operand A.
REQ-006 B  input  WIDTH  operand B.
REQ-007 shamt  input  5  shift amount for SLL.
REQ-008 cout  output  1  registered adder carry-out.
REQ-009 ovf  output  1  registered signed-overflow flag.
REQ-010 ze  output  1  registered zero flag.
REQ-011 R  output  WIDTH  registered result.

Function
REQ-012 Every rising clk edge with rst low SHALL register R, cout, ovf and ze from the current ctrl/A/B/shamt; latency is exactly 1 cycle; there is no stall or handshake, and a new operation is accepted every cycle.
REQ-013 ctrl=0 AND: R = A & B.
REQ-014 ctrl=1 OR: R = A | B.
REQ-015 ctrl=2 ADD (signed): R = (A + B) mod 2^WIDTH.
- cout = carry out of the MSB.
- ovf = 1 when A and B have equal sign bits and R's sign differs.
REQ-016 ctrl=3 SLT (signed): R = 1 if A < B in two's complement, else 0.
REQ-017 ctrl=4 ADDU: R = (A + B) mod 2^WIDTH; cout = MSB carry; ovf = 0.
REQ-018 ctrl=5 SLL: R = A << shamt, zero-filled, upper bits discarded; shamt=0 passes A.
REQ-019 ctrl=6 SUB (signed): R = A + ~B + 1.
- cout = carry out of that sum, i.e. 1 when there is no unsigned borrow.
- ovf = 1 when the signs of A and B differ and R's sign differs from A.
REQ-020 ctrl=7 SLTU: R = 1 if A < B unsigned, else 0.
REQ-021 cout SHALL be 0 for ctrl in {0,1,3,5,7}.
REQ-022 ovf SHALL be 0 for every ctrl other than 2 and 6.
REQ-023 ze SHALL be 1 exactly when the registered R is all zeros, for every ctrl.
REQ-024 shamt SHALL be ignored except for ctrl=5; changing shamt alone SHALL not alter other results.
REQ-025 SLT/SLTU comparisons SHALL be exact, i.e. not derived from an overflowing subtraction sign bit.
REQ-026 No input combination SHALL produce X on any output; all 8 ctrl codes are defined.

Reset
REQ-027 rst high SHALL immediately, without waiting for clk, force R=0, cout=0, ovf=0, ze=1.
REQ-028 Outputs SHALL hold their reset values while rst is high.
REQ-029 The first operation after rst deasserts SHALL appear after the first rising clk edge.
REQ-030 Reset asserted mid-stream SHALL discard the in-flight result.

Configuration
REQ-031 Macro ALU_UNIT_OVF_EN: when defined, ovf SHALL behave per REQ-015/019/022.
REQ-032 When ALU_UNIT_OVF_EN is undefined, ovf SHALL be constant 0 and no overflow logic is synthesized; all other outputs are unchanged.

Verification
REQ-033 ctrl=0, A=AAAAAAAA, B=FFFFFFFF -> next cycle R=AAAAAAAA, ze=0, cout=0, ovf=0.
REQ-034 ctrl=2 ADD cases (ovf checks with ALU_UNIT_OVF_EN defined):
- FFFFFFFF+00000001 -> R=0, cout=1, ovf=0, ze=1.
- 40000000+40000000 -> R=80000000, cout=0, ovf=1.
- 80000000+80000000 -> R=0, cout=1, ovf=1, ze=1.
REQ-035 A=80956829, B=60982375: ctrl=3 -> R=1; ctrl=7 -> R=0. A=FFFFFFFF, B=0: ctrl=3 -> R=1; ctrl=7 -> R=0.
REQ-036 ctrl=5, A=F0F0F0F0, shamt=5 -> R=1E1E1E00; ctrl=6, A=F0F0F0F0, B=00FF00F0 -> R=EFF1F000, cout=1, ovf=0.
REQ-037 Assert rst between clk edges with R nonzero -> R=0 and ze=1 before the next edge. Back-to-back ops on consecutive cycles -> each result appears one cycle later, none lost.
REQ-038 Build without ALU_UNIT_OVF_EN, rerun REQ-034 -> identical R/cout/ze, ovf=0 throughout.
